piso8: RTL

PISO8 -- requirements
Module: piso8

---
 rtl/piso8_pkg.sv | 19 +
 rtl/bit_counter.sv | 30 +++
 rtl/piso8.sv | 91 +++++++++
 3 files changed

// File: rtl/piso8_pkg.sv
// Shared definitions for the piso8 serializer: FSM encodings and counter sizing.
package piso8_pkg;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    // Bits needed to hold values 0..n-1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bit_counter.sv
// Down-counter for the bits remaining in a word; load sets WIDTH-1, stops at zero.
module bit_counter
    import piso8_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic ld,
    input  logic ena,
    output logic zero
);

    localparam int unsigned CW = clog2(WIDTH);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (ld) begin
            count <= CW'(WIDTH - 1);
        end else if (ena && (count != '0)) begin
            count <= count - CW'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/piso8.sv
// Parallel-in serial-out shifter with ready/valid/done framing and a global advance enable.
module piso8
    import piso8_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [WIDTH-1:0] data,
    input  logic             load,
    output logic             ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             done
);

    logic [0:0]       state, state_d;
    logic [WIDTH-1:0] sr, sr_d;
    logic             sout_d, valid_d;
    logic             cnt_ld, cnt_dec, cnt_zero;
    logic             accept;
    logic             load_bit, sr_bit;
    logic [WIDTH-1:0] load_rest, sr_rest;

    // First bit out and the remaining bits, for a fresh word and for the held word.
    assign load_bit  = MSB_FIRST ? data[WIDTH-1] : data[0];
    assign load_rest = MSB_FIRST ? {data[WIDTH-2:0], 1'b0} : {1'b0, data[WIDTH-1:1]};
    assign sr_bit    = MSB_FIRST ? sr[WIDTH-1] : sr[0];
    assign sr_rest   = MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};

    assign ready  = (state == IDLE) || cnt_zero;
    assign done   = sout_valid && cnt_zero;
    assign accept = load && ready && ena;

    bit_counter #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .ld   (cnt_ld),
        .ena  (cnt_dec),
        .zero (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            sr         <= '0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
        end else begin
            state      <= state_d;
            sr         <= sr_d;
            sout       <= sout_d;
            sout_valid <= valid_d;
        end
    end

    // A load on the retiring edge wins over the return to IDLE, giving gapless streams.
    always_comb begin
        state_d = state;
        sr_d    = sr;
        sout_d  = sout;
        valid_d = sout_valid;
        cnt_ld  = 1'b0;
        cnt_dec = 1'b0;
        if (ena) begin
            if (accept) begin
                state_d = SHIFT;
                sr_d    = load_rest;
                sout_d  = load_bit;
                valid_d = 1'b1;
                cnt_ld  = 1'b1;
            end else if (state == SHIFT) begin
                if (cnt_zero) begin
                    state_d = IDLE;
                    sr_d    = '0;
                    sout_d  = 1'b0;
                    valid_d = 1'b0;
                end else begin
                    sr_d    = sr_rest;
                    sout_d  = sr_bit;
                    cnt_dec = 1'b1;
                end
            end
        end
    end

endmodule
